// File: rtl/lut3_config_loader.sv
// lut3_config_loader: serial writer and readback checker for one 2^ADDR_BITS-entry LUT.
// A truth table taken on a valid/ready handshake is shifted into the LUT MSB
// first. Each bit uses one slot of STEP_CYCLES cycles, and the LUT shifts once,
// in the first cycle of the slot. When VERIFY is set, every address is then
// swept once and the LUT output is compared with the latched table.
//
//   state  | meaning
//   IDLE   | waiting for a table; tbl_ready high
//   SHIFT  | driving cfg_s / cfg_enable, one slot per table bit
//   VERIFY | sweeping lut_addr 0..N-1 and comparing lut_z with the table
//   DONE   | one-cycle done pulse; error / err_addr hold until the next accept

module lut3_config_loader #(
  parameter int ADDR_BITS   = 3,
  parameter int STEP_CYCLES = 1,
  parameter bit VERIFY      = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tbl_valid,
  output logic                        tbl_ready,
  input  logic [(1<<ADDR_BITS)-1:0]   tbl_data,
  output logic                        cfg_s,
  output logic                        cfg_enable,
  output logic [ADDR_BITS-1:0]        lut_addr,
  input  logic                        lut_z,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [ADDR_BITS-1:0]        err_addr
);

  localparam int N = 1 << ADDR_BITS;
  // Slot timer width. It stays at least 1 bit wide, even when STEP_CYCLES = 1
  // and the timer never counts.
  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] IDX_TOP   = ADDR_BITS'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           shadow_q, shadow_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]       step_q, step_d;
  logic                   cfg_s_q, cfg_s_d;
  logic                   cfg_en_q, cfg_en_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   error_q, error_d;
  logic [ADDR_BITS-1:0]   err_addr_q, err_addr_d;

  logic accept;
  logic slot_end;
  logic last_bit;
  logic last_addr;

  assign accept    = tbl_valid && (state_q == S_IDLE);
  assign slot_end  = (step_q == '0);
  assign last_bit  = (idx_q == '0);
  assign last_addr = (addr_q == IDX_TOP);

  // State register. The synchronous reset overrides every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: SHIFT ends on the last slot of bit 0, and VERIFY ends after address N-1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SHIFT;
      S_SHIFT:  if (slot_end && last_bit) state_d = VERIFY ? S_VERIFY : S_DONE;
      S_VERIFY: if (last_addr) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values: shadow table, bit index, slot timer, serial outputs, readback flags.
  always_comb begin
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    step_d     = step_q;
    cfg_s_d    = cfg_s_q;
    cfg_en_d   = 1'b0;
    addr_d     = addr_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shadow_d   = tbl_data;
          idx_d      = IDX_TOP;
          step_d     = STEP_LAST;
          cfg_s_d    = tbl_data[N-1];
          cfg_en_d   = 1'b1;
          addr_d     = '0;
          error_d    = 1'b0;
          err_addr_d = '0;
        end
      end
      S_SHIFT: begin
        if (!slot_end) begin
          // cfg_s holds its value for the rest of the slot. The enable was only high in the first cycle.
          step_d = step_q - 1'b1;
        end else if (!last_bit) begin
          idx_d    = idx_q - 1'b1;
          step_d   = STEP_LAST;
          cfg_s_d  = shadow_q[idx_q - 1'b1];
          cfg_en_d = 1'b1;
        end else begin
          cfg_s_d = 1'b0;
          addr_d  = '0;
        end
      end
      S_VERIFY: begin
        // Only the first mismatch is recorded.
        if ((lut_z != shadow_q[addr_q]) && !error_q) begin
          error_d    = 1'b1;
          err_addr_d = addr_q;
        end
        addr_d = last_addr ? '0 : addr_q + 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers. The LUT-facing outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      idx_q      <= '0;
      step_q     <= '0;
      cfg_s_q    <= 1'b0;
      cfg_en_q   <= 1'b0;
      addr_q     <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      cfg_s_q    <= cfg_s_d;
      cfg_en_q   <= cfg_en_d;
      addr_q     <= addr_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    tbl_ready = (state_q == S_IDLE);
    busy      = (state_q == S_SHIFT) || (state_q == S_VERIFY);
    done      = (state_q == S_DONE);
  end

  assign cfg_s      = cfg_s_q;
  assign cfg_enable = cfg_en_q;
  assign lut_addr   = addr_q;
  assign error      = error_q;
  assign err_addr   = err_addr_q;

endmodule
